// File: rtl/viterbi_frame_ctrl_if.sv
// Control, encoder-drive and decoder-return signals between the frame controller
// (slave side) and the encoder/channel/decoder environment (master side).
interface viterbi_frame_ctrl_if;
   logic        start_i;
   logic [15:0] seed_i;
   logic [15:0] inj_pos_i;
   logic [3:0]  inj_len_i;
   logic [1:0]  inj_mask_i;
   logic        dec_bit_i;
   logic        enc_en_o;
   logic        enc_bit_o;
   logic [1:0]  err_mask_o;
   logic        busy_o;
   logic        done_o;
   logic [15:0] inj_cnt_o;
   logic [15:0] err_cnt_o;

   modport slave (
      input  start_i, seed_i, inj_pos_i, inj_len_i, inj_mask_i, dec_bit_i,
      output enc_en_o, enc_bit_o, err_mask_o, busy_o, done_o, inj_cnt_o, err_cnt_o
   );

   modport master (
      output start_i, seed_i, inj_pos_i, inj_len_i, inj_mask_i, dec_bit_i,
      input  enc_en_o, enc_bit_o, err_mask_o, busy_o, done_o, inj_cnt_o, err_cnt_o
   );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for encoder2 -> channel -> decoder: PRBS frame + zero tail, burst error mask,
// delay-matched decode compare; done_o at start+2+FRAME_LEN+TAIL_LEN+ENC_LAT+DEC_LAT, no backpressure.
module viterbi_frame_ctrl #(
   parameter int FRAME_LEN = 256,
   parameter int TAIL_LEN  = 8,
   parameter int ENC_LAT   = 1,
   parameter int DEC_LAT   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   viterbi_frame_ctrl_if.slave   bus
);

   localparam int          SYM_N      = FRAME_LEN + TAIL_LEN;
   localparam int          PIPE       = ENC_LAT + DEC_LAT;
   localparam logic [15:0] LAST_SYM   = 16'(SYM_N - 1);
   localparam logic [15:0] DATA_END   = 16'(FRAME_LEN);
   // Drain spans the line depth plus the encoder output register and the compare register.
   localparam logic [15:0] DRAIN_LAST = 16'(PIPE + 1);
   localparam logic [15:0] LFSR_INIT  = 16'hACE1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] sym_cnt_q, sym_cnt_d;
   logic [15:0] drain_cnt_q, drain_cnt_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [15:0] pos_q, pos_d;
   logic [3:0]  len_q, len_d;
   logic [1:0]  mask_q, mask_d;
   logic        enc_en_q, enc_en_d;
   logic        enc_bit_q, enc_bit_d;
   logic        data_tag_q, data_tag_d;
   logic [1:0]  sym_mask_q, sym_mask_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] inj_cnt_q, inj_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   logic [1:0]  mask_line_q [ENC_LAT];
   logic [2:0]  ref_line_q  [PIPE];

   logic        is_data;
   logic        lfsr_fb;
   logic [16:0] win_end;
   logic        in_win;
   logic [1:0]  mask_pop;
   logic [2:0]  ref_tail;
   logic        bit_err;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {15'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   assign is_data  = (sym_cnt_q < DATA_END);
   assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   assign win_end  = {1'b0, pos_q} + {13'd0, len_q};
   assign in_win   = (len_q != 4'd0) && (sym_cnt_q >= pos_q) && ({1'b0, sym_cnt_q} < win_end);
   assign mask_pop = {1'b0, mask_q[1]} + {1'b0, mask_q[0]};
   // Tail entry fields: {valid, data-tagged, sent bit}.
   assign ref_tail = ref_line_q[PIPE-1];
   assign bit_err  = ref_tail[2] && ref_tail[1] && (ref_tail[0] != bus.dec_bit_i);

   always_comb begin
      state_d     = state_q;
      sym_cnt_d   = sym_cnt_q;
      drain_cnt_d = drain_cnt_q;
      lfsr_d      = lfsr_q;
      pos_d       = pos_q;
      len_d       = len_q;
      mask_d      = mask_q;
      enc_en_d    = 1'b0;
      enc_bit_d   = 1'b0;
      data_tag_d  = 1'b0;
      sym_mask_d  = 2'b00;
      inj_cnt_d   = inj_cnt_q;
      err_cnt_d   = bit_err ? sat_add(err_cnt_q, 2'd1) : err_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               pos_d       = bus.inj_pos_i;
               len_d       = bus.inj_len_i;
               mask_d      = bus.inj_mask_i;
               lfsr_d      = (bus.seed_i == 16'd0) ? LFSR_INIT : bus.seed_i;
               sym_cnt_d   = 16'd0;
               inj_cnt_d   = 16'd0;
               err_cnt_d   = 16'd0;
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            enc_en_d   = 1'b1;
            data_tag_d = is_data;
            enc_bit_d  = is_data & lfsr_q[0];
            if (is_data) begin
               lfsr_d = {lfsr_fb, lfsr_q[15:1]};
            end
            if (in_win) begin
               sym_mask_d = mask_q;
               inj_cnt_d  = sat_add(inj_cnt_q, mask_pop);
            end
            sym_cnt_d = sym_cnt_q + 16'd1;
            if (sym_cnt_q == LAST_SYM) begin
               drain_cnt_d = 16'd0;
               state_d     = S_DRAIN;
            end
         end
         S_DRAIN: begin
            drain_cnt_d = drain_cnt_q + 16'd1;
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sym_cnt_q   <= 16'd0;
         drain_cnt_q <= 16'd0;
         lfsr_q      <= LFSR_INIT;
         pos_q       <= 16'd0;
         len_q       <= 4'd0;
         mask_q      <= 2'b00;
         enc_en_q    <= 1'b0;
         enc_bit_q   <= 1'b0;
         data_tag_q  <= 1'b0;
         sym_mask_q  <= 2'b00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         inj_cnt_q   <= 16'd0;
         err_cnt_q   <= 16'd0;
      end else begin
         state_q     <= state_d;
         sym_cnt_q   <= sym_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         lfsr_q      <= lfsr_d;
         pos_q       <= pos_d;
         len_q       <= len_d;
         mask_q      <= mask_d;
         enc_en_q    <= enc_en_d;
         enc_bit_q   <= enc_bit_d;
         data_tag_q  <= data_tag_d;
         sym_mask_q  <= sym_mask_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         inj_cnt_q   <= inj_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // Mask line delays the per-symbol mask onto the encoder's output symbol; ENC_LAT >= 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENC_LAT; i++) begin
            mask_line_q[i] <= 2'b00;
         end
      end else begin
         mask_line_q[0] <= sym_mask_q;
         for (int i = 1; i < ENC_LAT; i++) begin
            mask_line_q[i] <= mask_line_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE; i++) begin
            ref_line_q[i] <= 3'b000;
         end
      end else begin
         ref_line_q[0] <= {enc_en_q, data_tag_q, enc_bit_q};
         for (int i = 1; i < PIPE; i++) begin
            ref_line_q[i] <= ref_line_q[i-1];
         end
      end
   end

   assign bus.enc_en_o   = enc_en_q;
   assign bus.enc_bit_o  = enc_bit_q;
   assign bus.err_mask_o = mask_line_q[ENC_LAT-1];
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.inj_cnt_o  = inj_cnt_q;
   assign bus.err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with a delay-line decoder stand-in that only
// mis-decodes a bit when both channel bits of its symbol were flipped.
module tb_viterbi_frame_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   viterbi_frame_ctrl_if vif();

   viterbi_frame_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (vif.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   // Decoder stand-in: bit sent in cycle c returns in cycle c+17; the channel mask
   // for that symbol appeared in cycle c+1.
   logic [17:0] bit_hist;
   logic [1:0]  mask_hist [17];
   initial begin
      bit_hist = '0;
      for (int i = 0; i < 17; i++) mask_hist[i] = 2'b00;
      vif.dec_bit_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bit_hist = {bit_hist[16:0], vif.enc_bit_o};
         for (int i = 16; i > 0; i--) mask_hist[i] = mask_hist[i-1];
         mask_hist[0] = vif.err_mask_o;
         vif.dec_bit_i = bit_hist[17] ^ (mask_hist[16] == 2'b11);
      end
   end

   task automatic run_frame(input string tag, input logic [15:0] seed, input logic [15:0] pos,
                            input logic [3:0] len, input logic [1:0] msk, input int pulse_off,
                            input int exp_inj, input int exp_err, input int exp_mcnt,
                            input int exp_mfirst);
      logic [15:0] model;
      int k, en_cnt, first_en, done_off, n_done, bit_bad, mcnt, mfirst, mbad;
      int inj_at_done, err_at_done, busy_end;
      k = 0; en_cnt = 0; first_en = -1; done_off = -1; n_done = 0; bit_bad = 0;
      mcnt = 0; mfirst = -1; mbad = 0; inj_at_done = -1; err_at_done = -1; busy_end = -1;
      model = (seed == 16'd0) ? 16'hACE1 : seed;
      @(negedge clk);
      vif.seed_i = seed; vif.inj_pos_i = pos; vif.inj_len_i = len; vif.inj_mask_i = msk;
      vif.start_i = 1'b1;
      for (int off = 0; off < 300; off++) begin
         @(posedge clk);
         #1;
         if (off == 0) chk({tag, "/busy_start"}, 32'(vif.busy_o), 1);
         if (vif.enc_en_o) begin
            en_cnt++;
            if (first_en < 0) first_en = off;
            if (k < 256) begin
               if (vif.enc_bit_o != model[0]) bit_bad++;
               model = lfsr_step(model);
            end else if (vif.enc_bit_o != 1'b0) begin
               bit_bad++;
            end
            k++;
         end
         if (vif.err_mask_o != 2'b00) begin
            mcnt++;
            if (mfirst < 0) mfirst = off;
            if (vif.err_mask_o != msk) mbad++;
         end
         if (vif.done_o) begin
            n_done++;
            done_off = off;
            inj_at_done = int'(vif.inj_cnt_o);
            err_at_done = int'(vif.err_cnt_o);
         end
         if (off == 284) busy_end = int'(vif.busy_o);
         vif.start_i = (off == pulse_off);
      end
      chk({tag, "/en_cycles"}, 32'(en_cnt), 264);
      chk({tag, "/first_sym"}, 32'(first_en), 1);
      chk({tag, "/enc_bits_bad"}, 32'(bit_bad), 0);
      chk({tag, "/done_cycle"}, 32'(done_off), 283);
      chk({tag, "/done_count"}, 32'(n_done), 1);
      chk({tag, "/busy_after"}, 32'(busy_end), 0);
      chk({tag, "/mask_cycles"}, 32'(mcnt), 32'(exp_mcnt));
      chk({tag, "/mask_value_bad"}, 32'(mbad), 0);
      if (exp_mcnt > 0) chk({tag, "/mask_first"}, 32'(mfirst), 32'(exp_mfirst));
      chk({tag, "/inj_cnt"}, 32'(inj_at_done), 32'(exp_inj));
      chk({tag, "/err_cnt"}, 32'(err_at_done), 32'(exp_err));
   endtask

   initial begin
      int n_done, d1, d2;
      vif.start_i = 1'b0; vif.seed_i = '0; vif.inj_pos_i = '0;
      vif.inj_len_i = '0; vif.inj_mask_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst/outs", 32'({vif.enc_en_o, vif.enc_bit_o, vif.err_mask_o, vif.busy_o, vif.done_o}), 0);
      chk("rst/inj", 32'(vif.inj_cnt_o), 0);
      chk("rst/err", 32'(vif.err_cnt_o), 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_frame("clean",  16'h0001, 16'd0,   4'd0, 2'b00, -1, 0,  0, 0, 0);
      run_frame("single", 16'h0000, 16'd40,  4'd1, 2'b01, -1, 1,  0, 1, 42);
      run_frame("burst",  16'hBEEF, 16'd100, 4'd8, 2'b11, -1, 16, 8, 8, 102);
      run_frame("clip",   16'h1357, 16'd262, 4'd5, 2'b11, -1, 4,  0, 2, 264);
      run_frame("midstart", 16'h00A5, 16'd0, 4'd0, 2'b10, 100, 0, 0, 0, 0);

      // start held high through DONE relaunches from IDLE with cleared counters
      n_done = 0; d1 = -1; d2 = -1;
      @(negedge clk);
      vif.seed_i = 16'h00FF; vif.inj_pos_i = 16'd10; vif.inj_len_i = 4'd2; vif.inj_mask_i = 2'b11;
      vif.start_i = 1'b1;
      for (int off = 0; off < 576; off++) begin
         @(posedge clk);
         #1;
         if (vif.done_o) begin
            n_done++;
            if (n_done == 1) d1 = off; else d2 = off;
            chk("held/inj_at_done", 32'(vif.inj_cnt_o), 4);
            chk("held/err_at_done", 32'(vif.err_cnt_o), 2);
         end
         if (off == 284) chk("held/idle_gap_busy", 32'(vif.busy_o), 0);
         if (off == 285) begin
            chk("held/relaunch_busy", 32'(vif.busy_o), 1);
            chk("held/inj_cleared", 32'(vif.inj_cnt_o), 0);
            chk("held/err_cleared", 32'(vif.err_cnt_o), 0);
            vif.start_i = 1'b0;
         end
      end
      chk("held/done_count", 32'(n_done), 2);
      chk("held/done1", 32'(d1), 283);
      chk("held/done2", 32'(d2), 568);

      // reset asserted while symbol 50 is on the encoder
      @(negedge clk);
      vif.seed_i = 16'h0005; vif.inj_pos_i = 16'd10; vif.inj_len_i = 4'd3; vif.inj_mask_i = 2'b11;
      vif.start_i = 1'b1;
      for (int off = 0; off <= 51; off++) begin
         @(posedge clk);
         #1;
         if (off == 0) vif.start_i = 1'b0;
      end
      chk("rstmid/busy_before", 32'(vif.busy_o), 1);
      chk("rstmid/inj_before", 32'(vif.inj_cnt_o), 6);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rstmid/outs", 32'({vif.enc_en_o, vif.enc_bit_o, vif.err_mask_o, vif.busy_o, vif.done_o}), 0);
      chk("rstmid/inj", 32'(vif.inj_cnt_o), 0);
      chk("rstmid/err", 32'(vif.err_cnt_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame("post_rst", 16'h1234, 16'd0, 4'd0, 2'b00, -1, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
